// File: rtl/dbus_wdt.sv
// dbus_wdt - watchdog timer peripheral on the data bus.
//
// A prescaled 32-bit down-counter. The first expiry raises wdt_irq_o. If
// RST_EN is set, the second expiry raises wdt_rst_req_o. Once that happens,
// the block is frozen until rst_n.
//
// Register map (addr[3:2]):
//   0x0 CTRL  [0] EN, [1] RST_EN, [2] LOCK, [15:8] PRESC (other bits read 0)
//   0x4 LOAD  reload value (takes effect at the next reload)
//   0x8 COUNT current count, read-only
//   0xC KICK  write-only, reads 0. Only a full-word write of KICK_KEY is accepted.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   dbus2peri_i    interconnect request (addr, w_data, sel_byte, w_en, req)
//   wdt_sel_i      block select from the address decoder
//   wdt2dbus_o     r_data/ack back to the interconnect; ack arrives one cycle after accept
//   wdt_irq_o      watchdog interrupt (level, registered)
//   wdt_rst_req_o  system reset request (level, registered)
//
// Build option: define WDT_LOCK_EN to implement CTRL.LOCK. When LOCK is set
// it stays set until reset, and it blocks CTRL/LOAD writes. Without
// WDT_LOCK_EN, CTRL[2] reads 0 and has no effect.

package dbus_wdt_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [3:0]  sel_byte;
    logic        w_en;
    logic        req;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;
endpackage

module dbus_wdt
  import dbus_wdt_pkg::*;
#(
  parameter logic [31:0] LOAD_RESET = 32'hFFFF_FFFF,
  parameter logic [31:0] KICK_KEY   = 32'h5A5A_5A5A
) (
  input  logic            rst_n,
  input  logic            clk,
  input  type_dbus2peri_s dbus2peri_i,
  input  logic            wdt_sel_i,
  output type_peri2dbus_s wdt2dbus_o,
  output logic            wdt_irq_o,
  output logic            wdt_rst_req_o
);

  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_IRQ, S_RESET} state_e;

  state_e      state_q, state_nxt;
  logic        en_q, rst_en_q, lock_q;
  logic [7:0]  presc_q, pre_q, pre_nxt;
  logic [31:0] load_q, load_wr_val, count_q, count_nxt;
  logic        irq_q, irq_nxt, rst_req_q;
  logic        ack_q;
  logic [31:0] r_data_q, rd_mux;

  logic        acc, wr, rd, cfg_ok, ctrl_wr, load_wr, kick, en_new, tick, running;
  logic [1:0]  idx;
  logic        unused_addr;

  assign unused_addr = ^{dbus2peri_i.addr[31:4], dbus2peri_i.addr[1:0]};

  // One access in flight. A new request is not taken in the ack cycle,
  // so back-to-back requests complete every two cycles.
  assign acc = dbus2peri_i.req & wdt_sel_i & ~ack_q;
  assign wr  = acc & dbus2peri_i.w_en;
  assign rd  = acc & ~dbus2peri_i.w_en;
  assign idx = dbus2peri_i.addr[3:2];

  // Config writes are dropped (but still acked) in RESET or while locked.
  assign cfg_ok  = (state_q != S_RESET) & ~lock_q;
  assign ctrl_wr = wr & (idx == 2'd0) & cfg_ok;
  assign load_wr = wr & (idx == 2'd1) & cfg_ok;
  assign en_new  = dbus2peri_i.sel_byte[0] ? dbus2peri_i.w_data[0] : en_q;

  assign running = (state_q == S_COUNT) | (state_q == S_IRQ);
  assign kick    = wr & (idx == 2'd3) & running & (dbus2peri_i.sel_byte == 4'hF) &
                   (dbus2peri_i.w_data == KICK_KEY);

  // Use >= so that lowering PRESC while the prescaler is past the new limit
  // still gives a tick instead of running through 255.
  assign tick = (pre_q >= presc_q);

  // Byte-lane merge for LOAD writes
  always_comb begin
    load_wr_val = load_q;
    for (int b = 0; b < NUM_LANES; b++)
      if (dbus2peri_i.sel_byte[b]) load_wr_val[b*8 +: 8] = dbus2peri_i.w_data[b*8 +: 8];
  end

  // Read mux. It samples the registers before any same-edge update.
  always_comb begin
    rd_mux = '0;
    case (idx)
      2'd0: rd_mux = {16'd0, presc_q, 5'd0, lock_q, rst_en_q, en_q};
      2'd1: rd_mux = load_q;
      2'd2: rd_mux = count_q;
      default: rd_mux = '0;
    endcase
  end

  // FSM next state. Priority in a running state is disable, then kick,
  // then tick/expiry.
  always_comb begin
    state_nxt = state_q;
    count_nxt = count_q;
    pre_nxt   = pre_q;
    irq_nxt   = irq_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && en_new) begin
          state_nxt = S_COUNT;
          count_nxt = load_q;
          pre_nxt   = '0;
        end
      end
      S_COUNT, S_IRQ: begin
        if (ctrl_wr && !en_new) begin
          state_nxt = S_IDLE;
          irq_nxt   = 1'b0;
        end else if (kick) begin
          state_nxt = S_COUNT;
          count_nxt = load_q;
          pre_nxt   = '0;
          irq_nxt   = 1'b0;
        end else begin
          pre_nxt = tick ? 8'd0 : pre_q + 8'd1;
          if (tick) begin
            if (count_q != '0) begin
              count_nxt = count_q - 32'd1;
            end else if (state_q == S_IRQ && rst_en_q) begin
              state_nxt = S_RESET;   // count stays frozen at 0
            end else begin
              state_nxt = S_IRQ;
              count_nxt = load_q;
              irq_nxt   = 1'b1;
            end
          end
        end
      end
      default: ;   // S_RESET: everything frozen until rst_n
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      pre_q     <= '0;
      irq_q     <= 1'b0;
      rst_req_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      count_q   <= count_nxt;
      pre_q     <= pre_nxt;
      irq_q     <= irq_nxt;
      rst_req_q <= (state_nxt == S_RESET);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      rst_en_q <= 1'b0;
      presc_q  <= '0;
      load_q   <= LOAD_RESET;
    end else begin
      if (ctrl_wr && dbus2peri_i.sel_byte[0]) begin
        en_q     <= dbus2peri_i.w_data[0];
        rst_en_q <= dbus2peri_i.w_data[1];
      end
      if (ctrl_wr && dbus2peri_i.sel_byte[1]) presc_q <= dbus2peri_i.w_data[15:8];
      if (load_wr) load_q <= load_wr_val;
    end
  end

`ifdef WDT_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_q <= 1'b0;
    else if (ctrl_wr && dbus2peri_i.sel_byte[0] && dbus2peri_i.w_data[2])
      lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

  // Bus response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      r_data_q <= '0;
    end else begin
      ack_q    <= acc;
      r_data_q <= rd ? rd_mux : 32'd0;
    end
  end

  assign wdt2dbus_o.ack    = ack_q;
  assign wdt2dbus_o.r_data = r_data_q;
  assign wdt_irq_o         = irq_q;
  assign wdt_rst_req_o     = rst_req_q;

endmodule

// File: tb/tb_dbus_wdt.sv
// Testbench for dbus_wdt. Every access is pushed to a scoreboard together
// with the cycle its ack is due and the read data it should return. A
// negedge monitor pops the entry on each ack. Each scenario task checks
// irq/rst_req inline at cycle points derived from the enable edge E.
module tb_dbus_wdt;
  import dbus_wdt_pkg::*;

  localparam logic [31:0] KEY = 32'h5A5A_5A5A;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  type_dbus2peri_s d;
  logic            sel;
  type_peri2dbus_s r;
  logic            irq, rstq;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        chk;
    logic [31:0] exp;
  } sb_t;
  sb_t   sb_q[$];
  string sb_nm[$];

  dbus_wdt dut (
    .rst_n(rst_n), .clk(clk), .dbus2peri_i(d), .wdt_sel_i(sel),
    .wdt2dbus_o(r), .wdt_irq_o(irq), .wdt_rst_req_o(rstq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    sb_t   it;
    string nm;
    if (rst_n) begin
      if (r.ack) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: ack at cyc %0d, want no ack", cyc);
        end else begin
          it = sb_q.pop_front();
          nm = sb_nm.pop_front();
          if (it.due != cyc || (it.chk && r.r_data !== it.exp)) begin
            bad++;
            $display("FAIL %s: ack cyc=%0d data=%h, want cyc=%0d data=%h",
                     nm, cyc, r.r_data, it.due, it.exp);
          end
        end
      end else begin
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
          total++; bad++;
          it = sb_q.pop_front();
          nm = sb_nm.pop_front();
          $display("FAIL %s: no ack by cyc %0d, want ack at cyc %0d", nm, cyc, it.due);
        end
        total++;
        if (r.r_data !== 32'd0) begin
          bad++;
          $display("FAIL rdata_idle: r_data=%h with ack=0, want 0", r.r_data);
        end
      end
    end
  end

  // One access. Called at a negedge; accepted at the next posedge; returns
  // two negedges later, so each call spans exactly two cycles.
  task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] dat,
                     input logic [3:0] sb, input logic chk, input logic [31:0] exp,
                     input string nm);
    d.addr = {28'd0, a}; d.w_data = dat; d.sel_byte = sb; d.w_en = w; d.req = 1'b1;
    sel = 1'b1;
    sb_q.push_back('{cyc + 1, chk, exp});
    sb_nm.push_back(nm);
    @(posedge clk); #1;
    d.req = 1'b0; d.w_en = 1'b0; sel = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] dat, input logic [3:0] sb);
    acc(1'b1, a, dat, sb, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    acc(1'b0, a, 32'd0, 4'hF, 1'b1, exp, nm);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb_q.delete(); sb_nm.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({irq, rstq, r.ack} !== 3'b000) begin
      bad++; $display("FAIL reset_out: irq/rst/ack=%b want 000", {irq, rstq, r.ack});
    end
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h0, 32'h0, "rst_ctrl");
    rd(4'h4, 32'hFFFF_FFFF, "rst_load");
    rd(4'h8, 32'h0, "rst_count");
    rd(4'hC, 32'h0, "rst_kick");
    wr(4'h8, 32'h77, 4'hF);            // COUNT is read-only
    rd(4'h8, 32'h0, "count_ro");
  endtask

  task automatic test_countdown();
    wr(4'h4, 32'd5, 4'hF);
    wr(4'h0, 32'h1, 4'hF);             // E: count=5
    rd(4'h8, 32'd4, "cnt_e2");         // accept E+2 -> value after E+1
    rd(4'h8, 32'd2, "cnt_e4");
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL irq_early: irq=%b want 0", irq); end
    rd(4'h8, 32'd0, "cnt_e6");         // expiry on this accept edge
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: irq=%b want 1", irq); end
    rd(4'h8, 32'd4, "cnt_reload");     // reloaded to 5 at E+6, 4 after E+7
    wr(4'h0, 32'h3, 4'hF);             // RST_EN=1 at E+10
    total++;
    if (rstq !== 1'b0) begin bad++; $display("FAIL rstreq_early: rst_req=%b want 0", rstq); end
    @(negedge clk);                    // after E+12: second expiry
    total++;
    if (rstq !== 1'b1) begin bad++; $display("FAIL rstreq_rise: rst_req=%b want 1", rstq); end
    wr(4'hC, KEY, 4'hF);               // no effect in RESET
    rd(4'h8, 32'd0, "cnt_frozen");
    wr(4'h0, 32'h0, 4'hF);             // ignored in RESET
    rd(4'h0, 32'h3, "ctrl_in_reset");
    total++;
    if (rstq !== 1'b1) begin bad++; $display("FAIL rstreq_hold: rst_req=%b want 1", rstq); end
  endtask

  task automatic test_presc();
    do_reset();
    total++;
    if (rstq !== 1'b0) begin bad++; $display("FAIL rstreq_clear: rst_req=%b want 0", rstq); end
    wr(4'h4, 32'd2, 4'hF);
    wr(4'h0, 32'h301, 4'b0011);        // E: PRESC=3, EN=1
    repeat (10) @(negedge clk);        // after E+11
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL presc_early: irq=%b want 0", irq); end
    @(negedge clk);                    // after E+12
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL presc_irq: irq=%b want 1", irq); end
    rd(4'h8, 32'd2, "presc_reload");
  endtask

  task automatic test_kick_expiry();
    do_reset();
    wr(4'h4, 32'd3, 4'hF);
    wr(4'h0, 32'h1, 4'hF);             // E: count=3, expiry due at E+4
    repeat (2) @(negedge clk);
    wr(4'hC, KEY, 4'hF);               // accepted exactly at E+4
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL kick_race_irq: irq=%b want 0", irq); end
    rd(4'h8, 32'd2, "kick_race_cnt");  // reload 3 at E+4, 2 after E+5
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL kick_race_hold: irq=%b want 0", irq); end
    @(negedge clk);                    // after E+8: first expiry -> IRQ
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL kick_race_next: irq=%b want 1", irq); end
  endtask

  task automatic test_bad_kick();
    do_reset();
    wr(4'h4, 32'd3, 4'hF);
    wr(4'h0, 32'h1, 4'hF);             // E
    wr(4'hC, 32'h1234_5678, 4'hF);     // wrong key at E+2
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL badkey_pre: irq=%b want 0", irq); end
    @(negedge clk);                    // after E+4
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL badkey_irq: irq=%b want 1", irq); end
    wr(4'hC, KEY, 4'b0011);            // partial kick, ignored
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL partkick: irq=%b want 1", irq); end
    wr(4'hC, KEY, 4'hF);               // valid kick in IRQ clears irq
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL kick_clr: irq=%b want 0", irq); end
  endtask

  task automatic test_byte_lanes();
    do_reset();
    wr(4'h4, 32'hAABB_CCDD, 4'hF);
    wr(4'h4, 32'h1122_3344, 4'b0101);
    rd(4'h4, 32'hAA22_CC44, "load_lanes");
    wr(4'h0, 32'h0000_FF01, 4'b0010);  // only PRESC lane written
    rd(4'h0, 32'h0000_FF00, "ctrl_lanes");
    rd(4'h8, 32'h0, "idle_count");
  endtask

  task automatic test_lock();
    do_reset();
    wr(4'h0, 32'h5, 4'hF);             // E
`ifdef WDT_LOCK_EN
    rd(4'h0, 32'h5, "lock_ctrl1");
    wr(4'h0, 32'h0, 4'hF);
    rd(4'h0, 32'h5, "lock_ctrl2");
    rd(4'h8, 32'hFFFF_FFF8, "lock_runs");  // still counting at E+8
    wr(4'h4, 32'h7, 4'hF);
    rd(4'h4, 32'hFFFF_FFFF, "lock_load");
`else
    rd(4'h0, 32'h1, "lock_ctrl1");
    wr(4'h0, 32'h0, 4'hF);             // disable at E+4
    rd(4'h0, 32'h0, "lock_ctrl2");
    rd(4'h8, 32'hFFFF_FFFC, "lock_runs");  // frozen at the E+3 value
    wr(4'h4, 32'h7, 4'hF);
    rd(4'h4, 32'h7, "lock_load");
`endif
  endtask

  task automatic test_back_to_back();
    do_reset();
    d.addr = 32'h4; d.w_en = 1'b0; d.sel_byte = 4'hF; d.req = 1'b1; sel = 1'b1;
    sb_q.push_back('{cyc + 1, 1'b1, 32'hFFFF_FFFF}); sb_nm.push_back("b2b_first");
    sb_q.push_back('{cyc + 3, 1'b1, 32'hFFFF_FFFF}); sb_nm.push_back("b2b_second");
    repeat (3) @(posedge clk);
    #1;
    d.req = 1'b0; sel = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_irq();
    do_reset();
    wr(4'h4, 32'd0, 4'hF);
    wr(4'h0, 32'h1, 4'hF);             // LOAD=0: expiry on every tick
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL load0_irq: irq=%b want 1", irq); end
    d.addr = 32'h8; d.w_en = 1'b0; d.sel_byte = 4'hF; d.req = 1'b1; sel = 1'b1;
    @(posedge clk); #2;
    total++;
    if (r.ack !== 1'b1) begin bad++; $display("FAIL pend_ack: ack=%b want 1", r.ack); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({irq, rstq, r.ack} !== 3'b000) begin
      bad++; $display("FAIL async_rst: irq/rst/ack=%b want 000", {irq, rstq, r.ack});
    end
    d.req = 1'b0; sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(4'h0, 32'h0, "post_rst_ctrl");
    rd(4'h8, 32'h0, "post_rst_count");
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL post_rst_irq: irq=%b want 0", irq); end
  endtask

  initial begin
    d = '0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_countdown();
    test_presc();
    test_kick_expiry();
    test_bad_kick();
    test_byte_lanes();
    test_lock();
    test_back_to_back();
    test_reset_irq();
    repeat (3) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_drain: %0d acks outstanding, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
